// File: rtl/uart_msg_pkg.sv
// Shared constants, state encodings and hex helpers for the UART message buffer.
package uart_msg_pkg;

  // ASCII characters used by the framing and checksum logic
  localparam logic [7:0] CHAR_DOLLAR = 8'h24;  // '$'
  localparam logic [7:0] CHAR_STAR   = 8'h2A;  // '*'
  localparam logic [7:0] CHAR_LF     = 8'h0A;  // line feed
  localparam logic [7:0] CHAR_0      = 8'h30;  // '0'
  localparam logic [7:0] CHAR_9      = 8'h39;  // '9'
  localparam logic [7:0] CHAR_UC_A   = 8'h41;  // 'A'
  localparam logic [7:0] CHAR_UC_F   = 8'h46;  // 'F'
  localparam logic [7:0] CHAR_LC_A   = 8'h61;  // 'a'
  localparam logic [7:0] CHAR_LC_F   = 8'h66;  // 'f'

  // Message framing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } msg_state_e;

  // Checksum parser phases: accumulate, expect high digit, expect low digit, done
  typedef enum logic [1:0] {
    CK_ACC  = 2'd0,
    CK_HI   = 2'd1,
    CK_LO   = 2'd2,
    CK_DONE = 2'd3
  } cks_phase_e;

  // Serial receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= CHAR_0)    && (c <= CHAR_9))    ||
           ((c >= CHAR_UC_A) && (c <= CHAR_UC_F)) ||
           ((c >= CHAR_LC_A) && (c <= CHAR_LC_F));
  endfunction

  // Value of a hex digit; only meaningful when is_hex(c) is true
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [7:0] t;
    t = 8'h00;
    if ((c >= CHAR_0) && (c <= CHAR_9))             t = c - CHAR_0;
    else if ((c >= CHAR_UC_A) && (c <= CHAR_UC_F))  t = c - CHAR_UC_A + 8'd10;
    else if ((c >= CHAR_LC_A) && (c <= CHAR_LC_F))  t = c - CHAR_LC_A + 8'd10;
    return t[3:0];
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, LSB first, one-cycle tvalid pulse.
module uart_rx
  import uart_msg_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int N_BITS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data,
  output logic [N_BITS-1:0] tdata,
  output logic              tvalid,
  input  logic              tready
);

  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic [N_BITS-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              meta_q, sync_q;

  // Two-flop synchroniser on the asynchronous serial line (idles high)
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_data;
      sync_q <= meta_q;
    end
  end

  // Next-state and datapath: find start edge, sample each bit at its centre
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~tready;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line back high at mid-start was a glitch, not a start bit
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[N_BITS-1:1]};
          if (bit_q == BIT_LAST) state_d = RX_STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_FULL) begin
          state_d = RX_IDLE;
          // Framing errors (stop bit low) are silently dropped
          if (sync_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receiver registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign tdata  = data_q;
  assign tvalid = valid_q;

endmodule

// File: rtl/uart_rx_msg_buff.sv
// Frames '$'...LF messages from a UART stream, buffers them and checks the '*HH' checksum.
module uart_rx_msg_buff
  import uart_msg_pkg::*;
#(
  parameter int         CLK_FREQ   = 25_000_000,
  parameter int         BAUD_RATE  = 115200,
  parameter int         N_BITS     = 8,
  parameter int         MAX_LEN    = 82,
  parameter logic [7:0] START_CHAR = CHAR_DOLLAR,
  parameter logic [7:0] END_CHAR   = CHAR_LF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_data,
  output logic [N_BITS*MAX_LEN-1:0]      msg_tdata,
  output logic [$clog2(MAX_LEN+1)-1:0]   msg_len,
  output logic                           msg_tvalid,
  input  logic                           msg_tready,
  output logic                           cks_present,
  output logic                           cks_ok,
  output logic [7:0]                     drop_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [N_BITS-1:0] rx_byte;
  logic              rx_valid;
  logic [7:0]        cks_char;

  msg_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        xor_q, xor_d;
  cks_phase_e        phase_q, phase_d;
  logic [7:0]        cks_val_q, cks_val_d;
  logic              cks_bad_q, cks_bad_d;
  logic              present_q, present_d;
  logic [7:0]        drop_q, drop_d;

  logic [N_BITS-1:0] buf_q [MAX_LEN];
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [N_BITS-1:0] wr_data;

  logic              do_start, do_store, do_drop;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .N_BITS    (N_BITS)
  ) u_uart_rx (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .tdata   (rx_byte),
    .tvalid  (rx_valid),
    .tready  (1'b1)
  );

  assign cks_char = 8'(rx_byte);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus per-character action strobes (start / store / drop)
  always_comb begin
    state_d  = state_q;
    do_start = 1'b0;
    do_store = 1'b0;
    do_drop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == START_CHAR)) begin
          do_start = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (rx_valid) begin
          if (rx_byte == START_CHAR) begin
            do_start = 1'b1;
          end else if (len_q == LEN_MAX) begin
            // No room left, even for the terminator: the message is lost
            do_drop = 1'b1;
            state_d = ST_IDLE;
          end else begin
            do_store = 1'b1;
            if (rx_byte == END_CHAR) state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (msg_tready) begin
          // Handshake cycle: the incoming character follows idle rules
          state_d = ST_IDLE;
          if (rx_valid && (rx_byte == START_CHAR)) begin
            do_start = 1'b1;
            state_d  = ST_FILL;
          end
        end else if (rx_valid && (rx_byte == START_CHAR)) begin
          do_drop = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer write port, length, checksum parsing and drop counter
  always_comb begin
    len_d     = len_q;
    xor_d     = xor_q;
    phase_d   = phase_q;
    cks_val_d = cks_val_q;
    cks_bad_d = cks_bad_q;
    present_d = present_q;
    drop_d    = drop_q;
    wr_en     = 1'b0;
    wr_idx    = len_q[IDX_W-1:0];
    wr_data   = rx_byte;
    if (do_start) begin
      wr_en     = 1'b1;
      wr_idx    = '0;
      len_d     = LEN_W'(1);
      xor_d     = 8'h00;
      phase_d   = CK_ACC;
      cks_val_d = 8'h00;
      cks_bad_d = 1'b0;
      present_d = 1'b0;
    end
    if (do_store) begin
      wr_en = 1'b1;
      len_d = len_q + LEN_W'(1);
      case (phase_q)
        CK_ACC: begin
          if (cks_char == CHAR_STAR) begin
            present_d = 1'b1;
            phase_d   = CK_HI;
          end else if (rx_byte != END_CHAR) begin
            xor_d = xor_q ^ cks_char;
          end
        end
        CK_HI: begin
          // A terminator here leaves the phase short of done, so cks_ok stays 0
          if (rx_byte != END_CHAR) begin
            if (is_hex(cks_char)) cks_val_d[7:4] = hex_val(cks_char);
            else                  cks_bad_d      = 1'b1;
            phase_d = CK_LO;
          end
        end
        CK_LO: begin
          if (rx_byte != END_CHAR) begin
            if (is_hex(cks_char)) cks_val_d[3:0] = hex_val(cks_char);
            else                  cks_bad_d      = 1'b1;
            phase_d = CK_DONE;
          end
        end
        default: ;
      endcase
    end
    if (do_drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Message storage; stale entries beyond len_q are masked at the output
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx] <= wr_data;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      xor_q     <= 8'h00;
      phase_q   <= CK_ACC;
      cks_val_q <= 8'h00;
      cks_bad_q <= 1'b0;
      present_q <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      len_q     <= len_d;
      xor_q     <= xor_d;
      phase_q   <= phase_d;
      cks_val_q <= cks_val_d;
      cks_bad_q <= cks_bad_d;
      present_q <= present_d;
      drop_q    <= drop_d;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    msg_tvalid  = (state_q == ST_READY);
    msg_len     = len_q;
    cks_present = present_q;
    cks_ok      = present_q && !cks_bad_q && (phase_q == CK_DONE) && (cks_val_q == xor_q);
    drop_cnt    = drop_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_out
      assign msg_tdata[N_BITS*gi +: N_BITS] = (LEN_W'(gi) < len_q) ? buf_q[gi] : '0;
    end
  endgenerate

endmodule

// File: doc/uart_rx_msg_buff.md
UART_RX_MSG_BUFF -- requirements
Module: uart_rx_msg_buff

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial line rate.
REQ-003 SHALL have parameter N_BITS, default 8, data bits per character; the checksum logic is defined for 8 only.
REQ-004 SHALL have parameter MAX_LEN, default 82, maximum message length in characters, including start and end characters.
REQ-005 SHALL have parameter START_CHAR, default 8'h24 ('$'), which opens a message.
REQ-006 SHALL have parameter END_CHAR, default 8'h0A (LF), which closes a message.
REQ-007 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous and active-high.
- rx_data  in  1  serial UART line.
- msg_tdata  out  N_BITS*MAX_LEN  message; character i at bits [N_BITS*(i+1)-1 : N_BITS*i].
- msg_len  out  clog2(MAX_LEN+1)  character count, including START_CHAR and END_CHAR.
- msg_tvalid  out  1  message available.
- msg_tready  in  1  consumer accepts the message.
- cks_present  out  1  message contained '*'.
- cks_ok  out  1  transmitted checksum matches the computed one.
- drop_cnt  out  8  saturating count of lost messages.

Function
REQ-008 SHALL deserialise characters with an internal uart_rx instance, holding its tready at 1 so every character is consumed in the cycle its tvalid is seen.
REQ-009 SHALL implement FSM states IDLE, FILL and READY.
REQ-010 IDLE: SHALL discard every character except START_CHAR.
- On START_CHAR: store it at index 0, set length to 1, clear the buffer tail, XOR and checksum state, then go to FILL.
REQ-011 FILL, character == START_CHAR: SHALL restart the message as in REQ-010, with no drop counted.
REQ-012 FILL, character == END_CHAR: SHALL store it, increment the length, and go to READY.
REQ-013 FILL, other character with length < MAX_LEN: SHALL store it at index = length and increment the length.
REQ-014 FILL, non-END character arriving with length == MAX_LEN: SHALL discard the message, increment drop_cnt, and go to IDLE.
REQ-015 FILL, END_CHAR arriving with length == MAX_LEN: SHALL also count as overflow, as in REQ-014.
REQ-016 READY: SHALL hold msg_tvalid=1, with msg_tdata, msg_len, cks_present and cks_ok stable until the handshake.
REQ-017 READY, START_CHAR received without a handshake in the same cycle: SHALL increment drop_cnt and leave the held message unchanged; all other characters are ignored.
REQ-018 Handshake (msg_tvalid & msg_tready): SHALL take msg_tvalid low on the next cycle.
- The character arriving in the handshake cycle SHALL be processed with IDLE rules, so START_CHAR goes straight to FILL.
REQ-019 Character positions at index >= msg_len SHALL read as zero.
REQ-020 Checksum accumulation: SHALL XOR all characters strictly between START_CHAR and the first '*'.
- On '*', SHALL set cks_present and parse the next two characters as hex (0-9, A-F, a-f).
REQ-021 Checksum result: cks_ok SHALL be 1 only if both characters after '*' are valid hex and equal the XOR.
- A non-hex character, or END_CHAR arriving before two digits are parsed, SHALL give cks_ok=0.
- Further characters after the two digits SHALL be stored but not checked.
REQ-022 cks_present and cks_ok SHALL be 0 when no '*' was received.
REQ-023 drop_cnt SHALL saturate at 255.
REQ-024 Latency: msg_tvalid SHALL rise on the cycle after END_CHAR's uart_rx tvalid.

Reset
REQ-025 On rst, outputs SHALL be: state IDLE, msg_tvalid=0, msg_len=0, msg_tdata=0, cks_present=0, cks_ok=0, drop_cnt=0.
- The uart_rx instance SHALL be reset too.
REQ-026 rst asserted during FILL or READY SHALL discard the message without counting a drop.

Structure
REQ-027 State encoding and ASCII constants ('$', '*', LF, the hex digit bounds) SHALL live in shared package uart_msg_pkg.
REQ-028 SHALL instantiate exactly one sub-module, the existing uart_rx; the framing, buffer and checksum logic SHALL live in this module.

Verification
All scenarios use CLK_FREQ=1_000_000, BAUD_RATE=100_000, MAX_LEN=16, and msg_tready=1 unless stated.
REQ-029 Send "$AB*03\n" -> msg_len=7, byte0=0x24, byte6=0x0A, cks_present=1, cks_ok=1, drop_cnt=0.
REQ-030 Send "$AB*04\n" -> msg_len=7, cks_present=1, cks_ok=0.
REQ-031 Send "xyz$Q\n" -> msg_len=3, bytes 0x24,0x51,0x0A, bytes 3..15 zero, cks_present=0.
REQ-032 Send '$' plus 20 'A' with no LF, then "$Q\n" -> no msg_tvalid during the long frame, drop_cnt=1, then the second message is delivered with msg_len=3.
REQ-033 msg_tready=0, send "$A\n" then "$B\n", then raise msg_tready:
- the held message is "$A\n" throughout, drop_cnt=1;
- one handshake occurs, after which msg_tvalid=0.
REQ-034 Assert rst for 1 cycle mid-FILL of "$ABC", then send "$Z\n" -> outputs at reset values after rst, then msg_len=3 with byte1=0x5A and drop_cnt=0.
